// File: rtl/fcl_pro_array.sv
// fcl_pro_array: binary-weight fully-connected PE array.
// Streams signed pixels, accumulates +/-pixel per neuron over a vector
// delimited by in_last (or forced at MAX_LEN), then applies an arithmetic
// right shift and saturates each neuron to OUT_W bits.
// Optional feature macro: FCL_PRO_BIAS_EN adds a per-neuron bias_in port
// that seeds the accumulators on the first beat of each vector.
module fcl_pro_array #(
  parameter int PIX_W   = 8,
  parameter int PAR     = 16,
  parameter int ACC_W   = 24,
  parameter int OUT_W   = 8,
  parameter int MAX_LEN = 1024,
  parameter int SH_W    = 5
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [PIX_W-1:0]       in_data,
  input  logic [PAR-1:0]         in_w,
  input  logic                   in_last,
  input  logic [SH_W-1:0]        shift,
`ifdef FCL_PRO_BIAS_EN
  input  logic [PAR*ACC_W-1:0]   bias_in,
`endif
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [PAR*OUT_W-1:0]   out_data,
  output logic                   len_err
);

  localparam int CNT_W = $clog2(MAX_LEN + 1);
  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_LEN);

  if (ACC_W < PIX_W + $clog2(MAX_LEN) + 1) begin : g_acc_w_check
    $error("fcl_pro_array: ACC_W too narrow for PIX_W and MAX_LEN");
  end

  typedef enum logic [1:0] {
    IDLE,
    ACC,
    DRAIN
  } state_e;

  state_e                  state_q, state_d;
  logic signed [ACC_W-1:0] acc_q [PAR];
  logic signed [ACC_W-1:0] acc_d [PAR];
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic [SH_W-1:0]         shift_q, shift_d;
  logic [PAR*OUT_W-1:0]    out_data_q, out_data_d;
  logic                    len_err_q, len_err_d;

  logic [SH_W-1:0]         sh_sel;
  int unsigned             sh_amt;
  logic signed [PIX_W:0]   pix_ext;
  logic [PAR*ACC_W-1:0]    sum_flat;
  logic [PAR*OUT_W-1:0]    sat_flat;
  logic [CNT_W-1:0]        cnt_inc;

  // Shift amount: live input on the first beat, latched value afterwards.
  // Amounts beyond ACC_W-1 are clamped, which gives the same sign fill.
  always_comb begin
    sh_sel  = (state_q == IDLE) ? shift : shift_q;
    sh_amt  = 32'(sh_sel);
    if (sh_amt > unsigned'(ACC_W - 1)) sh_amt = unsigned'(ACC_W - 1);
    pix_ext = {in_data[PIX_W-1], in_data};
  end

  for (genvar g = 0; g < PAR; g++) begin : g_pe
    logic signed [PIX_W:0]   c_full;
    logic signed [ACC_W-1:0] contrib;
    logic signed [ACC_W-1:0] base;
    logic signed [ACC_W-1:0] sum;
    logic signed [ACC_W-1:0] shd;
    logic [ACC_W-OUT_W:0]    hi;

    // One extra bit of headroom so negating the most negative pixel cannot wrap.
    assign c_full  = in_w[g] ? pix_ext : -pix_ext;
    assign contrib = {{(ACC_W-PIX_W-1){c_full[PIX_W]}}, c_full};
`ifdef FCL_PRO_BIAS_EN
    assign base    = (state_q == IDLE) ? bias_in[g*ACC_W +: ACC_W] : acc_q[g];
`else
    assign base    = (state_q == IDLE) ? '0 : acc_q[g];
`endif
    assign sum     = base + contrib;
    assign shd     = sum >>> sh_amt;
    // Fits in OUT_W iff all bits from OUT_W-1 upward agree with the sign.
    assign hi      = shd[ACC_W-1:OUT_W-1];
    assign sat_flat[g*OUT_W +: OUT_W] =
      (&hi || ~|hi) ? shd[OUT_W-1:0] :
      (shd[ACC_W-1] ? {1'b1, {(OUT_W-1){1'b0}}} : {1'b0, {(OUT_W-1){1'b1}}});
    assign sum_flat[g*ACC_W +: ACC_W] = sum;
  end

  // Next-state, handshake and register-update logic.
  always_comb begin
    state_d    = state_q;
    acc_d      = acc_q;
    cnt_d      = cnt_q;
    shift_d    = shift_q;
    out_data_d = out_data_q;
    len_err_d  = len_err_q;
    in_ready   = 1'b0;
    out_valid  = 1'b0;
    cnt_inc    = (state_q == IDLE) ? CNT_W'(1) : cnt_q + CNT_W'(1);

    case (state_q)
      IDLE, ACC: begin
        in_ready = 1'b1;
        if (in_valid) begin
          for (int unsigned i = 0; i < PAR; i++) begin
            acc_d[i] = sum_flat[i*ACC_W +: ACC_W];
          end
          cnt_d = cnt_inc;
          if (state_q == IDLE) shift_d = shift;
          if (in_last || (cnt_inc == MAX_CNT)) begin
            state_d    = DRAIN;
            out_data_d = sat_flat;
            len_err_d  = !in_last;
          end else begin
            state_d = ACC;
          end
        end
      end
      DRAIN: begin
        out_valid = 1'b1;
        if (out_ready) begin
          state_d   = IDLE;
          len_err_d = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers with asynchronous reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      for (int unsigned i = 0; i < PAR; i++) acc_q[i] <= '0;
      cnt_q      <= '0;
      shift_q    <= '0;
      out_data_q <= '0;
      len_err_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      acc_q      <= acc_d;
      cnt_q      <= cnt_d;
      shift_q    <= shift_d;
      out_data_q <= out_data_d;
      len_err_q  <= len_err_d;
    end
  end

  assign out_data = out_data_q;
  assign len_err  = len_err_q;

endmodule

// File: tb/tb_fcl_pro_array.sv
// Scoreboard bench for fcl_pro_array (PAR=4, MAX_LEN=4).
module tb_fcl_pro_array;
  localparam int PIX_W   = 8;
  localparam int PAR     = 4;
  localparam int ACC_W   = 24;
  localparam int OUT_W   = 8;
  localparam int MAX_LEN = 4;
  localparam int SH_W    = 5;

  logic                 clk, rst;
  logic                 in_valid, in_ready, in_last;
  logic [PIX_W-1:0]     in_data;
  logic [PAR-1:0]       in_w;
  logic [SH_W-1:0]      shift;
  logic                 out_valid, out_ready, len_err;
  logic [PAR*OUT_W-1:0] out_data;
`ifdef FCL_PRO_BIAS_EN
  logic [PAR*ACC_W-1:0] bias_in;
  assign bias_in = '0;
`endif

  fcl_pro_array #(
    .PIX_W(PIX_W), .PAR(PAR), .ACC_W(ACC_W), .OUT_W(OUT_W),
    .MAX_LEN(MAX_LEN), .SH_W(SH_W)
  ) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .in_w(in_w), .in_last(in_last), .shift(shift),
`ifdef FCL_PRO_BIAS_EN
    .bias_in(bias_in),
`endif
    .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .len_err(len_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [PAR*OUT_W-1:0] data;
    logic                 le;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  logic hold_req = 1'b0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: plain integer sums per neuron, per-vector shift, clamp.
  int m_sum [PAR];
  int m_cnt   = 0;
  int m_shift = 0;

  task automatic model_beat(input int d, input logic [PAR-1:0] w, input logic last, input int sh);
    exp_t e;
    int   v;
    int   lim;
    lim = 2 ** (OUT_W - 1);
    if (m_cnt == 0) begin
      m_shift = sh;
      for (int i = 0; i < PAR; i++) m_sum[i] = 0;
    end
    for (int i = 0; i < PAR; i++) m_sum[i] += w[i] ? d : -d;
    m_cnt++;
    if (last || m_cnt == MAX_LEN) begin
      for (int i = 0; i < PAR; i++) begin
        v = m_sum[i] >>> m_shift;
        if (v > lim - 1) v = lim - 1;
        if (v < -lim) v = -lim;
        e.data[i*OUT_W +: OUT_W] = v[OUT_W-1:0];
      end
      e.le = !last;
      exp_q.push_back(e);
      m_cnt = 0;
    end
  endtask

  // Called at a negedge; returns at the negedge after the beat is accepted.
  task automatic send_beat(input int d, input logic [PAR-1:0] w, input logic last,
                           input int sh, input int gap);
    logic got;
    int   guard;
    if (gap > 0) begin
      in_valid = 1'b0;
      repeat (gap) @(negedge clk);
    end
    in_valid = 1'b1;
    in_data  = d[PIX_W-1:0];
    in_w     = w;
    in_last  = last;
    shift    = sh[SH_W-1:0];
    guard    = 0;
    got      = 1'b0;
    while (!got) begin
      got = in_ready;
      @(posedge clk);
      if (!got) begin
        @(negedge clk);
        guard++;
        if (guard > 200) begin
          n_checks++;
          n_fail++;
          $display("FAIL beat_accept_timeout: in_ready stuck low at %0t", $time);
          break;
        end
      end
    end
    if (got) model_beat(d, w, last, sh);
    @(negedge clk);
  endtask

  task automatic drain_wait();
    int guard;
    in_valid = 1'b0;
    guard = 0;
    while ((exp_q.size() != 0 || out_valid) && guard < 500) begin
      @(negedge clk);
      guard++;
    end
    n_checks++;
    if (guard >= 500) begin
      n_fail++;
      $display("FAIL drain_timeout: %0d results outstanding at %0t", exp_q.size(), $time);
    end
  endtask

  // Monitor: drives out_ready, pops expectations on handshakes, checks hold stability.
  logic                 stalled = 1'b0;
  logic [PAR*OUT_W-1:0] held_data;
  logic                 held_le;
  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      stalled   = 1'b0;
      out_ready = 1'b0;
    end else begin
      if (stalled) begin
        check("stall_valid", {31'b0, out_valid}, 32'd1);
        check("stall_data", out_data, held_data);
        check("stall_len_err", {31'b0, len_err}, {31'b0, held_le});
      end
      out_ready = hold_req ? 1'b0 : ($urandom_range(0, 3) != 0);
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_result: data 0x%08h with empty scoreboard", out_data);
        end else begin
          e = exp_q.pop_front();
          check("out_data", out_data, e.data);
          check("len_err", {31'b0, len_err}, {31'b0, e.le});
        end
      end
      stalled   = out_valid && !out_ready;
      held_data = out_data;
      held_le   = len_err;
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] r;
    int len;
    in_valid = 1'b0; in_data = '0; in_w = '0; in_last = 1'b0; shift = '0;
    out_ready = 1'b0;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_in_ready", {31'b0, in_ready}, 32'd1);
    check("rst_out_valid", {31'b0, out_valid}, 32'd0);
    check("rst_out_data", out_data, 32'd0);
    check("rst_len_err", {31'b0, len_err}, 32'd0);
    rst = 1'b0;
    @(negedge clk);

    // Two-beat vector; result must be valid one cycle after the last beat.
    send_beat(10, 4'b0011, 1'b0, 0, 0);
    send_beat(-3, 4'b0101, 1'b1, 0, 0);
    check("latency_valid", {31'b0, out_valid}, 32'd1);
    drain_wait();

    // Saturation, then shift=2 on the same pattern.
    for (int k = 0; k < 4; k++) send_beat(127, 4'b0101, k == 3, 0, 0);
    drain_wait();
    for (int k = 0; k < 4; k++) send_beat(127, 4'b0101, k == 3, 2, 0);
    drain_wait();

    // Most negative pixel negated on a single-beat vector.
    send_beat(-128, 4'b0001, 1'b1, 0, 0);
    drain_wait();

    // Backpressure: DRAIN holds, in_valid is ignored.
    hold_req = 1'b1;
    @(negedge clk);
    send_beat(50, 4'b1010, 1'b1, 1, 0);
    in_valid = 1'b1; in_data = 8'd7; in_w = 4'b1111; in_last = 1'b1; shift = '0;
    for (int k = 0; k < 5; k++) begin
      check("hold_in_ready", {31'b0, in_ready}, 32'd0);
      check("hold_out_valid", {31'b0, out_valid}, 32'd1);
      @(negedge clk);
    end
    hold_req = 1'b0;
    send_beat(7, 4'b1111, 1'b1, 0, 0);
    drain_wait();

    // Forced termination at MAX_LEN, fifth beat starts a new vector.
    for (int k = 0; k < 5; k++) send_beat(1, 4'b1111, 1'b0, 0, 0);
    send_beat(1, 4'b1111, 1'b1, 0, 0);
    drain_wait();

    // Reset mid-vector discards partial sums.
    send_beat(9, 4'b1111, 1'b0, 0, 0);
    send_beat(9, 4'b1111, 1'b0, 0, 0);
    in_valid = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    m_cnt = 0;
    for (int k = 0; k < 3; k++) begin
      check("abort_out_valid", {31'b0, out_valid}, 32'd0);
      check("abort_in_ready", {31'b0, in_ready}, 32'd1);
      @(negedge clk);
    end
    send_beat(5, 4'b1111, 1'b1, 0, 0);
    drain_wait();

    // Randomized vectors with bubbles and per-beat shift noise.
    for (int v = 0; v < 60; v++) begin
      len = $urandom_range(1, 6);
      for (int b = 0; b < len; b++) begin
        r = $urandom;
        send_beat($signed(r[7:0]), r[11:8], b == len - 1,
                  (r[13:12] == 2'b00) ? int'(r[20:16]) : int'(r[22:21]),
                  (r[25:24] == 2'b00) ? int'(r[27:26]) : 0);
      end
    end
    drain_wait();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/fcl_pro_array.md
Name: fcl_pro_array

Overview:
Parametrised successor of the binary fully-connected processing element array. It streams signed pixels with per-neuron binary weights over a valid/ready handshake and accumulates ±pixel per neuron across a variable-length vector delimited by in_last. It applies a runtime arithmetic shift and saturates each result to OUT_W, then presents all PAR results on a valid/ready output port. It sits between the activation stream buffer and the next layer's input FIFO.

Parameters:
PIX_W, 8, signed input pixel width
PAR, 16, number of output neurons (parallel PEs)
ACC_W, 24, signed accumulator width per neuron
OUT_W, 8, signed output width per neuron
MAX_LEN, 1024, maximum beats per vector before forced termination
SH_W, 5, width of shift control

Ports:
clk  in  1  clock
rst  in  1  asynchronous active-high reset
in_valid  in  1  input beat valid
in_ready  out  1  input beat accepted when in_valid&in_ready
in_data  in  PIX_W  signed pixel
in_w  in  PAR  weight bits, bit i: 1 = +1, 0 = -1
in_last  in  1  final beat of vector
shift  in  SH_W  arithmetic right-shift amount, sampled on first beat
out_valid  out  1  results valid
out_ready  in  1  downstream accepts results
out_data  out  PAR*OUT_W  neuron i at bits [i*OUT_W +: OUT_W], signed
len_err  out  1  vector was force-terminated at MAX_LEN; qualified by out_valid

Behaviour:
- Reset is the decided interface: one clock, clk; reset rst is asynchronous and active-high. Under reset: state=IDLE, all acc=0, out_data=0, out_valid=0, len_err=0, beat count=0, shift_q=0. in_ready is 1 after reset.
- Per-beat contribution for neuron i: c_i = in_w[i] ? +in_data : -in_data. Computed at full precision, then sign-extended to ACC_W. -(-2^(PIX_W-1)) must produce +2^(PIX_W-1) with no wrap. This equals the halved ±1 sum of a 2^PIX_W-bit thermometer code, so the two formulations are interchangeable.
- FSM states:
  - IDLE: in_ready=1. An accepted beat does acc_i<=c_i, shift_q<=shift, cnt<=1, then goes to DRAIN if in_last, otherwise ACC.
  - ACC: in_ready=1. An accepted beat does acc_i<=acc_i+c_i, cnt<=cnt+1. It goes to DRAIN if in_last or cnt+1==MAX_LEN. On MAX_LEN without in_last, the length-error flag is set.
  - DRAIN: in_ready=0, out_valid=1. When out_ready is high, go to IDLE and clear out_valid and len_err.
- Cycles with no accepted beat leave acc, cnt and state unchanged. Bubbles are allowed anywhere.
- Output register: on the cycle the terminating beat is accepted, load out_data_i = sat_OUT_W((acc_i+c_i) >>> shift_q). On a single-beat vector, use c_i >>> shift. Saturation bounds are [-2^(OUT_W-1), 2^(OUT_W-1)-1].
- Latency: out_valid is asserted the cycle after the terminating beat is accepted. out_data and len_err stay stable while out_valid=1 && out_ready=0.
- Throughput: one beat per cycle. There is at least one DRAIN cycle per vector; the next vector's first beat can be accepted the cycle after the out handshake.
- Accumulator arithmetic is two's-complement wrap at ACC_W. The integrator guarantees ACC_W ≥ PIX_W+clog2(MAX_LEN)+1, checked by an elaboration assertion.
- Shift ≥ ACC_W yields 0 or -1 (sign fill).
- In DRAIN, in_valid is ignored: no state change and no data captured.
- Reset asserted mid-vector or mid-DRAIN discards the partial sum and pending results immediately. No output handshake completes for that vector.

Optional Feature:
FCL_PRO_BIAS_EN:
- When defined, adds port bias_in (in, PAR*ACC_W, signed per neuron). bias_in is sampled on the first beat, and the first beat does acc_i<=bias_i+c_i.
- When undefined, the port is absent and acc starts at c_i, which is identical to bias=0.

Test Plan:
- PAR=4, shift=0: beats (10, w=0011, last=0), (-3, w=0101, last=1) -> out_data = {n3=-7, n2=-13, n1=13, n0=7}, len_err=0, out_valid one cycle after the second beat.
- Four beats of 127 with w=1111/0000 alternate neurons (w=0101 each beat), shift=0 -> n0=127 (saturated from 508), n1=-128 (saturated from -508). Repeat with shift=2 -> n0=127, n1=-127.
- Single beat -128, w=0001, last=1, shift=0 -> n0=-128, n1=127 (saturated from +128), with no internal wrap.
- Hold out_ready=0 for 5 cycles while driving in_valid=1 -> in_ready=0 throughout, out_data stable, the next vector is unaffected once out_ready=1.
- MAX_LEN=4, five beats of 1, w=1111, no in_last -> forced DRAIN after beat 4 with n_i=4 and len_err=1. The fifth beat is accepted only after the handshake, as the first beat of a new vector.
- Assert rst for 1 cycle after 2 of 3 beats -> out_valid stays 0. A fresh vector (5, w=1111, last) yields n_i=5, with no residue from the aborted vector.
